// File: rtl/noc_tx_arbiter.sv
// Packet-level tx buffer scheduler: weighted forward priority, port round-robin and a
// starvation override. One whole-packet grant decision per fclk cycle.
module noc_tx_arbiter #(
  parameter int unsigned PORTS        = 4,
  parameter int unsigned FWD_WEIGHT   = 4,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned BUF_LEN      = 256
) (
  input  logic                      fclk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      fwd_req,
  input  logic [7:0]                fwd_len,
  output logic                      fwd_gnt,
  input  logic [PORTS-1:0]          prt_req,
  input  logic [PORTS*8-1:0]        prt_len,
  output logic [PORTS-1:0]          prt_gnt,
  input  logic [$clog2(BUF_LEN):0]  buf_space,
  output logic [3:0]                gnt_src,
  output logic [7:0]                gnt_len,
  output logic                      err_len,
  output logic [3:0]                err_src,
  output logic [15:0]               pkt_cnt
);

  localparam logic [3:0] FwdSrc = 4'd15;
  localparam logic [3:0] Weight = 4'(FWD_WEIGHT);
  localparam logic [7:0] Limit  = 8'(STARVE_LIMIT);

  logic [3:0]  rr_q, rr_d;
  logic [3:0]  credit_q, credit_d;
  logic [7:0]  starve_q [PORTS];
  logic [7:0]  starve_d [PORTS];
  logic        err_q, err_d;
  logic [3:0]  err_src_q, err_src_d;
  logic [15:0] cnt_q, cnt_d;

  logic             fwd_legal, fwd_elig;
  logic [PORTS-1:0] prt_legal, prt_elig;
  logic             ovr_hit, rr_hit;
  int               ovr_idx, rr_idx, gnt_idx;
  logic [7:0]       ovr_len, rr_len;
  logic             gnt_f, gnt_p;

  function automatic logic len_ok(input logic [7:0] len);
    return (len >= 8'd2) && (len <= 8'd36);
  endfunction

  // Eligibility, candidate selection and grant outputs.
  always_comb begin
    int j;
    fwd_legal = len_ok(fwd_len);
    fwd_elig  = !rst && !hold && fwd_req && fwd_legal && (32'(fwd_len) <= 32'(buf_space));
    for (int i = 0; i < int'(PORTS); i++) begin
      prt_legal[i] = len_ok(prt_len[8*i +: 8]);
      prt_elig[i]  = !rst && !hold && prt_req[i] && prt_legal[i] &&
                     (32'(prt_len[8*i +: 8]) <= 32'(buf_space));
    end

    // Walk downward so the lowest starved index wins.
    ovr_hit = 1'b0;
    ovr_idx = 0;
    ovr_len = 8'd0;
    for (int i = int'(PORTS) - 1; i >= 0; i--) begin
      if (prt_elig[i] && starve_q[i] == Limit) begin
        ovr_hit = 1'b1;
        ovr_idx = i;
        ovr_len = prt_len[8*i +: 8];
      end
    end

    rr_hit = 1'b0;
    rr_idx = 0;
    rr_len = 8'd0;
    j      = 0;
    for (int k = 0; k < int'(PORTS); k++) begin
      j = (int'(rr_q) + k) % int'(PORTS);
      if (!rr_hit && prt_elig[j]) begin
        rr_hit = 1'b1;
        rr_idx = j;
        rr_len = prt_len[8*j +: 8];
      end
    end

    gnt_f   = 1'b0;
    gnt_p   = 1'b0;
    gnt_idx = 0;
    gnt_len = 8'd0;
    if (ovr_hit) begin
      gnt_p   = 1'b1;
      gnt_idx = ovr_idx;
      gnt_len = ovr_len;
    end else if (fwd_elig && credit_q != 4'd0) begin
      gnt_f   = 1'b1;
      gnt_len = fwd_len;
    end else if (rr_hit) begin
      gnt_p   = 1'b1;
      gnt_idx = rr_idx;
      gnt_len = rr_len;
    end else if (fwd_elig) begin
      gnt_f   = 1'b1;
      gnt_len = fwd_len;
    end

    fwd_gnt = gnt_f;
    prt_gnt = '0;
    if (gnt_p) prt_gnt[gnt_idx] = 1'b1;
    gnt_src = gnt_f ? FwdSrc : (gnt_p ? 4'(gnt_idx) : 4'd0);
  end

  always_comb begin
    rr_d      = rr_q;
    credit_d  = credit_q;
    err_d     = err_q;
    err_src_d = err_src_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < int'(PORTS); i++) starve_d[i] = starve_q[i];

    if (gnt_f || gnt_p) cnt_d = cnt_q + 16'd1;

    if (!hold) begin
      if (gnt_p && !ovr_hit) rr_d = 4'((gnt_idx + 1) % int'(PORTS));
      if (gnt_f && |prt_elig) credit_d = credit_q - 4'd1;
      else if (gnt_p || !(|prt_elig)) credit_d = Weight;
      for (int i = 0; i < int'(PORTS); i++) begin
        if (prt_elig[i] && !(gnt_p && gnt_idx == i)) begin
          starve_d[i] = (starve_q[i] == Limit) ? Limit : starve_q[i] + 8'd1;
        end else begin
          starve_d[i] = 8'd0;
        end
      end
    end

    // First illegal length wins; forward beats ports, lower port beats higher.
    if (!err_q) begin
      if (fwd_req && !fwd_legal) begin
        err_d     = 1'b1;
        err_src_d = FwdSrc;
      end else begin
        for (int i = int'(PORTS) - 1; i >= 0; i--) begin
          if (prt_req[i] && !prt_legal[i]) begin
            err_d     = 1'b1;
            err_src_d = 4'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      rr_q      <= 4'd0;
      credit_q  <= Weight;
      err_q     <= 1'b0;
      err_src_q <= 4'd0;
      cnt_q     <= 16'd0;
      for (int i = 0; i < int'(PORTS); i++) starve_q[i] <= 8'd0;
    end else begin
      rr_q      <= rr_d;
      credit_q  <= credit_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < int'(PORTS); i++) starve_q[i] <= starve_d[i];
    end
  end

  assign err_len = err_q;
  assign err_src = err_src_q;
  assign pkt_cnt = cnt_q;

endmodule
